// File: rtl/rv_if_pkg.sv
// Shared types and widths for the instruction-fetch prefetch buffer.
package rv_if_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

    // One buffered fetch: the PC it was fetched from and the returned instruction.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Bundle of PC-register, instruction-memory and decode handshake signals
// around the prefetch buffer. master = prefetch buffer, slave = its environment.
interface if_prefetch_buffer_if;
    import rv_if_pkg::*;

    logic [XLEN-1:0] pc_i;
    logic            pc_write_o;
    logic            flush_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;
    logic            id_valid_o;
    logic [ILEN-1:0] id_instr_o;
    logic [XLEN-1:0] id_pc_o;
    logic            id_ready_i;
    logic            empty_o;

    modport master (
        input  pc_i,
        output pc_write_o,
        input  flush_i,
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output id_valid_o,
        output id_instr_o,
        output id_pc_o,
        input  id_ready_i,
        output empty_o
    );

    modport slave (
        output pc_i,
        input  pc_write_o,
        output flush_i,
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  id_valid_o,
        input  id_instr_o,
        input  id_pc_o,
        output id_ready_i,
        input  empty_o
    );

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with a synchronous clear; head word is read combinationally.
module if_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && (r_count < CW'(DEPTH));
    assign w_pop   = pop_i && (r_count != '0);
    assign rdata_o = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // Storage array; cleared on reset so an empty FIFO reads as zero.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); clear wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: issues fetches at pc_i while credit remains,
// pairs in-order responses with their PCs and hands them to decode.
// Responses still in flight at a redirect are counted and silently dropped.
module if_prefetch_buffer
    import rv_if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    if_prefetch_buffer_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [CW-1:0]   w_buf_count;
    logic [CW-1:0]   w_pend_count;
    logic [SW-1:0]   w_inflight;
    logic [XLEN-1:0] w_pend_pc;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_req;
    logic            w_grant;
    logic            w_rsp_keep;
    logic            w_valid;
    logic            w_pop;

    // Credit covers both buffered entries and fetches still in flight.
    assign w_inflight = SW'(w_buf_count) + SW'(r_outstanding);
    assign w_req      = rst_n && !bus.flush_i && (w_inflight < SW'(DEPTH));
    assign w_grant    = w_req && bus.imem_gnt_i;

    // A response is kept only if it belongs to a post-redirect fetch.
    assign w_rsp_keep = bus.imem_rvalid_i && !bus.flush_i && (r_drop == '0);

    assign w_valid = (w_buf_count != '0);
    assign w_pop   = w_valid && bus.id_ready_i && !bus.flush_i;

    assign w_push_entry = '{pc: w_pend_pc, instr: bus.imem_rdata_i};

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = bus.pc_i;
    assign bus.pc_write_o  = w_grant || bus.flush_i;
    assign bus.id_valid_o  = w_valid;
    assign bus.id_pc_o     = w_head.pc;
    assign bus.id_instr_o  = w_head.instr;
    assign bus.empty_o     = !w_valid;

    // Next values of the outstanding and drop counters.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_drop_nxt        = r_drop;
        if (w_grant) begin
            w_outstanding_nxt = w_outstanding_nxt + CW'(1);
        end
        if (bus.imem_rvalid_i) begin
            w_outstanding_nxt = w_outstanding_nxt - CW'(1);
        end
        if (bus.flush_i) begin
            w_drop_nxt = r_outstanding - CW'(bus.imem_rvalid_i);
        end else if (bus.imem_rvalid_i && (r_drop != '0)) begin
            w_drop_nxt = r_drop - CW'(1);
        end
    end

    // Outstanding-fetch and pending-drop counters.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    if_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .clear_i (bus.flush_i),
        .push_i  (w_rsp_keep),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (w_buf_count)
    );

    if_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pend_pc (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .clear_i (bus.flush_i),
        .push_i  (w_grant),
        .wdata_i (bus.pc_i),
        .pop_i   (w_rsp_keep),
        .rdata_o (w_pend_pc),
        .count_o (w_pend_count)
    );

    // A response can only arrive for a fetch that was granted.
    a_rvalid_has_fetch: assert property (
        @(posedge clk_i) disable iff (!rst_n)
        bus.imem_rvalid_i |-> (r_outstanding != '0));

    // Every in-flight fetch not marked for dropping has its PC queued.
    a_pend_tracks_fetches: assert property (
        @(posedge clk_i) disable iff (!rst_n)
        w_pend_count == CW'(r_outstanding - r_drop));

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: PC register, instruction memory and decode are
// modelled here; a queue-based reference predicts every output each cycle.
module tb_if_prefetch_buffer;
    import rv_if_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_n;

    if_prefetch_buffer_if bus ();

    if_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp;
    int n_bad;

    // Reference model state
    logic [XLEN-1:0] m_buf_pc [$];
    logic [ILEN-1:0] m_buf_in [$];
    logic [XLEN-1:0] m_pend   [$];
    int              m_out;
    int              m_drop;

    // Memory: granted addresses in order, with earliest response cycle
    logic [XLEN-1:0] mem_addr [$];
    int              mem_due  [$];

    int              cyc;
    int              n_grant;
    logic [XLEN-1:0] pc;

    // Stimulus knobs: probabilities (percent) and forced values (-1 = random)
    int p_gnt, p_rv, p_rdy, p_flush;
    int f_gnt, f_rv, f_rdy, f_flush;
    int fix_tgt;

    // Per-cycle history of model predictions
    logic            h_req   [$];
    logic            h_pcw   [$];
    logic            h_valid [$];
    logic            h_empty [$];
    logic [XLEN-1:0] h_pop   [$];

    function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] a);
        return RV_NOP ^ (a * 32'h9E37_79B9);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic knobs(input int g, input int r, input int d, input int f);
        p_gnt = g; p_rv = r; p_rdy = d; p_flush = f;
        f_gnt = -1; f_rv = -1; f_rdy = -1; f_flush = -1; fix_tgt = -1;
    endtask

    // Async reset from the current point; returns at a falling edge with rst_n high.
    task automatic apply_reset(input logic [XLEN-1:0] start_pc);
        rst_n              = 1'b0;
        bus.flush_i        = 1'b0;
        bus.imem_gnt_i     = 1'b0;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = '0;
        bus.id_ready_i     = 1'b0;
        pc                 = start_pc;
        bus.pc_i           = pc;
        #1;
        check("rst_id_valid", bus.id_valid_o, 0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_req", bus.imem_req_o, 0);
        check("rst_pc_write", bus.pc_write_o, 0);
        check("rst_id_instr", bus.id_instr_o, 0);
        check("rst_id_pc", bus.id_pc_o, 0);
        m_buf_pc.delete(); m_buf_in.delete(); m_pend.delete();
        m_out = 0; m_drop = 0;
        mem_addr.delete(); mem_due.delete();
        h_req.delete(); h_pcw.delete(); h_valid.delete(); h_empty.delete(); h_pop.delete();
        n_grant = 0;
        @(negedge clk_i);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model.
    task automatic step();
        logic            gnt, rv, rdy, fl;
        logic            e_req, e_grant, e_pcw, e_valid, e_pop;
        logic [XLEN-1:0] rdata, tgt, pc_next;

        fl  = (f_flush >= 0) ? (f_flush != 0) : (int'($urandom_range(99)) < p_flush);
        gnt = (f_gnt   >= 0) ? (f_gnt   != 0) : (int'($urandom_range(99)) < p_gnt);
        rdy = (f_rdy   >= 0) ? (f_rdy   != 0) : (int'($urandom_range(99)) < p_rdy);
        rv  = 1'b0;
        if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            rv = (f_rv >= 0) ? (f_rv != 0) : (int'($urandom_range(99)) < p_rv);
        end
        rdata = $urandom();
        if (rv) rdata = instr_of(mem_addr[0]);
        if (fix_tgt >= 0) tgt = XLEN'(fix_tgt);
        else begin
            tgt = $urandom();
            tgt = tgt & 32'h0000_FFFC;
        end

        bus.flush_i       = fl;
        bus.imem_gnt_i    = gnt;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rdata;
        bus.id_ready_i    = rdy;
        #1;

        e_req   = !fl && (m_buf_pc.size() + m_out < int'(DEPTH));
        e_grant = e_req && gnt;
        e_pcw   = e_grant || fl;
        e_valid = m_buf_pc.size() > 0;
        e_pop   = e_valid && rdy && !fl;

        check("imem_req", bus.imem_req_o, e_req);
        check("imem_addr", bus.imem_addr_o, pc);
        check("pc_write", bus.pc_write_o, e_pcw);
        check("id_valid", bus.id_valid_o, e_valid);
        check("empty", bus.empty_o, !e_valid);
        if (e_valid) begin
            check("id_pc", bus.id_pc_o, m_buf_pc[0]);
            check("id_instr", bus.id_instr_o, m_buf_in[0]);
        end
        h_req.push_back(e_req);
        h_pcw.push_back(e_pcw);
        h_valid.push_back(e_valid);
        h_empty.push_back(!e_valid);

        if (e_pop) begin
            h_pop.push_back(m_buf_pc[0]);
            void'(m_buf_pc.pop_front());
            void'(m_buf_in.pop_front());
        end
        if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
            if (!fl) begin
                if (m_drop > 0) m_drop--;
                else begin
                    m_buf_pc.push_back(m_pend.pop_front());
                    m_buf_in.push_back(rdata);
                end
            end
        end
        if (fl) begin
            m_buf_pc.delete(); m_buf_in.delete(); m_pend.delete();
            m_out  = m_out - (rv ? 1 : 0);
            m_drop = m_out;
        end else begin
            m_out = m_out + (e_grant ? 1 : 0) - (rv ? 1 : 0);
        end
        if (e_grant) begin
            m_pend.push_back(pc);
            mem_addr.push_back(pc);
            mem_due.push_back(cyc + 1);
            n_grant++;
        end
        pc_next = fl ? tgt : (e_pcw ? pc + 32'd4 : pc);
        cyc++;

        @(posedge clk_i);
        #1;
        pc       = pc_next;
        bus.pc_i = pc;
        @(negedge clk_i);
    endtask

    function automatic int count_ones(input int from);
        int n = 0;
        for (int i = from; i < h_pcw.size(); i++) if (h_pcw[i]) n++;
        return n;
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; n_grant = 0;
        knobs(100, 100, 100, 0);

        // Streaming: grant every cycle, 1-cycle response, decode always ready
        apply_reset(32'h0);
        repeat (10) step();
        check("A_valid_c1", h_valid[1], 0);
        check("A_valid_c2", h_valid[2], 1);
        check("A_pop0", h_pop[0], 32'h0);
        check("A_pop1", h_pop[1], 32'h4);
        check("A_pop2", h_pop[2], 32'h8);
        check("A_pop3", h_pop[3], 32'hC);
        check("A_pcw_all", count_ones(0), 10);

        // Decode stalled: credit stops requests after DEPTH grants
        apply_reset(32'h0);
        knobs(100, 100, 0, 0);
        repeat (8) step();
        check("B_grants", n_grant, DEPTH);
        check("B_req_off", h_req[h_req.size()-1], 0);
        check("B_pcw_off", h_pcw[h_pcw.size()-1], 0);
        f_rdy = 1;
        step();
        check("B_req_pop_cycle", h_req[h_req.size()-1], 0);
        step();
        check("B_req_resume", h_req[h_req.size()-1], 1);
        repeat (8) step();
        check("B_drain0", h_pop[0], 32'h0);
        check("B_drain3", h_pop[3], 32'hC);

        // Memory not granting: PC held
        apply_reset(32'h40);
        knobs(0, 100, 100, 0);
        f_gnt = 0;
        repeat (3) step();
        check("C_pcw_none", count_ones(0), 0);
        check("C_pc_held", pc, 32'h40);

        // Redirect with two fetches in flight
        apply_reset(32'h0);
        knobs(100, 0, 100, 0);
        f_gnt = 1; f_rv = 0;
        repeat (2) step();
        f_flush = 1; fix_tgt = 32'h100;
        step();
        check("D_drop", m_drop, 2);
        f_flush = 0; f_rv = -1; p_rv = 100;
        repeat (10) step();
        check("D_first_after_flush", h_pop[0], 32'h100);

        // Redirect coinciding with a response and a ready decode
        apply_reset(32'h0);
        knobs(100, 100, 0, 0);
        f_gnt = 1; f_rv = 0; f_rdy = 0; step();
        f_gnt = 1; f_rv = 1; f_rdy = 0; step();
        f_gnt = 0; f_rv = 0; f_rdy = 0; step();
        check("E_head_before", h_valid[h_valid.size()-1], 1);
        f_flush = 1; f_rv = 1; f_rdy = 1; step();
        check("E_no_pop", h_pop.size(), 0);
        f_flush = 0; f_rv = 0; f_gnt = 0; step();
        check("E_empty_after", h_empty[h_empty.size()-1], 1);
        check("E_drop", m_drop, 0);

        // Asynchronous reset with two buffered entries
        apply_reset(32'h0);
        knobs(100, 100, 0, 0);
        f_gnt = 1; f_rdy = 0;
        repeat (3) step();
        check("F_buffered", m_buf_pc.size(), 2);
        check("F_pre_valid", bus.id_valid_o, 1);
        apply_reset(32'h200);

        // Random soak
        knobs(70, 60, 60, 3);
        repeat (3000) step();
        knobs(95, 90, 30, 8);
        repeat (1500) step();
        apply_reset(32'h1000);
        knobs(50, 40, 85, 2);
        repeat (2000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
